// File: rtl/serial_frame_pkg.sv
// Shared widths, FIFO depth and collector state encoding for the serial frame collector.
package serial_frame_pkg;

    localparam int unsigned FRAME_W    = 8;
    localparam int unsigned SLOT_W     = 3;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned CNT_W      = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    typedef logic [FRAME_W-1:0] frame_t;

endpackage

// File: rtl/frame_fifo2.sv
// Two-entry frame FIFO; the head entry is held in its own register so dout needs no read mux.
module frame_fifo2
    import serial_frame_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    input  frame_t din,
    output frame_t dout,
    output logic   empty,
    output logic   full
);

    frame_t tail;
    logic   do_pop;
    logic   do_push;

    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout  <= '0;
            tail  <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else if (do_pop && do_push) begin
            if (full) begin
                dout <= tail;
                tail <= din;
            end else begin
                dout <= din;
            end
        end else if (do_pop) begin
            dout  <= tail;
            empty <= ~full;
            full  <= 1'b0;
        end else if (do_push) begin
            if (empty) begin
                dout  <= din;
                empty <= 1'b0;
            end else begin
                tail <= din;
                full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_frame_collector.sv
// Assembles slot-tagged serial bits into bytes, checks slot order and queues frames in a 2-entry FIFO.
module serial_frame_collector
    import serial_frame_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_in,
    input  logic [SLOT_W-1:0] slot,
    input  logic              bit_valid,
    input  logic              frame_ready,
    output frame_t            frame_data,
    output logic              frame_valid,
    output logic              slot_err,
    output logic              overflow,
    output logic [CNT_W-1:0]  frame_count
);

    state_t              state, state_n;
    logic [SLOT_W-1:0]   expected, expected_n;
    logic [FRAME_W-2:0]  shift, shift_n;
    logic                err_n;
    logic                complete;
    logic                fifo_empty;
    logic                fifo_full;
    logic                pop;
    logic                push;
    frame_t              frame_word;

    assign frame_valid = ~fifo_empty;
    assign pop         = frame_valid & frame_ready;
    assign push        = complete & (~fifo_full | pop);
    assign frame_word  = {bit_in, shift};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            expected    <= '0;
            shift       <= '0;
            slot_err    <= 1'b0;
            overflow    <= 1'b0;
            frame_count <= '0;
        end else begin
            state    <= state_n;
            expected <= expected_n;
            shift    <= shift_n;
            slot_err <= err_n;
            if (push) begin
                frame_count <= frame_count + CNT_W'(1);
            end
            if (complete && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Next-state, slot checking and frame completion.
    always_comb begin
        state_n    = state;
        expected_n = expected;
        shift_n    = shift;
        err_n      = 1'b0;
        complete   = 1'b0;

        if (bit_valid) begin
            unique case (state)
                IDLE: begin
                    if (slot == '0) begin
                        shift_n    = '0;
                        shift_n[0] = bit_in;
                        expected_n = SLOT_W'(1);
                        state_n    = COLLECT;
                    end
                end
                COLLECT: begin
                    if (slot == expected) begin
                        if (slot == SLOT_W'(FRAME_W - 1)) begin
                            complete   = 1'b1;
                            expected_n = '0;
                            state_n    = IDLE;
                        end else begin
                            for (int unsigned k = 0; k < FRAME_W - 1; k++) begin
                                if (slot == SLOT_W'(k)) begin
                                    shift_n[k] = bit_in;
                                end
                            end
                            expected_n = expected + SLOT_W'(1);
                        end
                    end else begin
                        // Out-of-order slot drops the partial frame; a slot 0 immediately reopens one.
                        err_n = 1'b1;
                        if (slot == '0) begin
                            shift_n    = '0;
                            shift_n[0] = bit_in;
                            expected_n = SLOT_W'(1);
                            state_n    = COLLECT;
                        end else begin
                            shift_n    = '0;
                            expected_n = '0;
                            state_n    = IDLE;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    frame_fifo2 u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push),
        .pop   (pop),
        .din   (frame_word),
        .dout  (frame_data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_serial_frame_collector.sv
// Bench for serial_frame_collector: vector table, directed corner sequences and a randomized run against a queue-based model.
module tb_serial_frame_collector;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       bit_in = 1'b0;
    logic [2:0] slot = 3'd0;
    logic       bit_valid = 1'b0;
    logic       frame_ready = 1'b0;
    logic [7:0] frame_data;
    logic       frame_valid;
    logic       slot_err;
    logic       overflow;
    logic [7:0] frame_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_frame_collector dut (
        .clk         (clk),
        .reset       (reset),
        .bit_in      (bit_in),
        .slot        (slot),
        .bit_valid   (bit_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .slot_err    (slot_err),
        .overflow    (overflow),
        .frame_count (frame_count)
    );

    // Behavioural model: frames as a byte queue, position in frame as an int (-1 = waiting for slot 0).
    logic [7:0] mq[$];
    int         m_next;
    logic [7:0] m_part;
    logic [7:0] m_cnt;
    logic       m_ovf;
    logic       m_err;

    typedef struct {
        logic       bv;
        logic       bi;
        logic [2:0] sl;
        logic       fr;
        logic       valid;
        logic [7:0] data;
        logic       err;
        logic       ovf;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_next = -1;
        m_part = '0;
        m_cnt  = '0;
        m_ovf  = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_edge(input logic bv, input logic bi, input logic [2:0] sl, input logic fr);
        int  sz;
        bit  do_pop;
        bit  done;
        sz     = mq.size();
        do_pop = (sz > 0) && fr;
        done   = 0;
        m_err  = 1'b0;
        if (bv) begin
            if (m_next < 0) begin
                if (sl == 3'd0) begin
                    m_part    = '0;
                    m_part[0] = bi;
                    m_next    = 1;
                end
            end else if (int'(sl) == m_next) begin
                m_part[sl] = bi;
                if (sl == 3'd7) begin
                    done   = 1;
                    m_next = -1;
                end else begin
                    m_next++;
                end
            end else begin
                m_err = 1'b1;
                if (sl == 3'd0) begin
                    m_part    = '0;
                    m_part[0] = bi;
                    m_next    = 1;
                end else begin
                    m_next = -1;
                end
            end
        end
        if (do_pop) void'(mq.pop_front());
        if (done) begin
            if (sz < 2 || do_pop) begin
                mq.push_back(m_part);
                m_cnt = m_cnt + 8'd1;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    // Drive one cycle of inputs, take the clock edge, sample 1ns later.
    task automatic step(input logic bv, input logic bi, input logic [2:0] sl, input logic fr);
        bit_valid   = bv;
        bit_in      = bi;
        slot        = sl;
        frame_ready = fr;
        @(posedge clk);
        model_edge(bv, bi, sl, fr);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset     = 1'b0;
        bit_valid = 1'b0;
        #1;
        chk("rst_valid", 8'(frame_valid), 8'd0);
        chk("rst_data", frame_data, 8'h00);
        chk("rst_err", 8'(slot_err), 8'd0);
        chk("rst_ovf", 8'(overflow), 8'd0);
        chk("rst_cnt", frame_count, 8'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic fr_body, input logic fr_last);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, b[k], 3'(k), (k == 7) ? fr_last : fr_body);
        end
    endtask

    function automatic vec_t mk(input logic bv, input logic bi, input logic [2:0] sl, input logic fr,
                                input logic valid, input logic [7:0] data, input logic err,
                                input logic ovf, input logic [7:0] cnt);
        vec_t v;
        v.bv = bv; v.bi = bi; v.sl = sl; v.fr = fr;
        v.valid = valid; v.data = data; v.err = err; v.ovf = ovf; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        logic [7:0] b;
        int         tn;
        logic       rbv;
        logic [2:0] rsl;

        model_reset();

        // Table: basic assembly, idle slot filtering, slot error and clean recovery.
        b = 8'h8D;
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(1'b1, b[k], 3'(k), 1'b1, k == 7, (k == 7) ? 8'h8D : 8'h00, 1'b0, 1'b0,
                              (k == 7) ? 8'd1 : 8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1));
        vecs.push_back(mk(1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1));
        vecs.push_back(mk(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1));
        vecs.push_back(mk(1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1));
        vecs.push_back(mk(1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1));
        vecs.push_back(mk(1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'd1));
        vecs.push_back(mk(1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1));
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(1'b1, 1'b1, 3'(k), 1'b1, k == 7, (k == 7) ? 8'hFF : 8'h00, 1'b0, 1'b0,
                              (k == 7) ? 8'd2 : 8'd1));
        vecs.push_back(mk(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd2));

        do_reset();
        foreach (vecs[i]) begin
            step(vecs[i].bv, vecs[i].bi, vecs[i].sl, vecs[i].fr);
            chk($sformatf("vec%0d_valid", i), 8'(frame_valid), 8'(vecs[i].valid));
            chk($sformatf("vec%0d_err", i), 8'(slot_err), 8'(vecs[i].err));
            chk($sformatf("vec%0d_ovf", i), 8'(overflow), 8'(vecs[i].ovf));
            chk($sformatf("vec%0d_cnt", i), frame_count, vecs[i].cnt);
            if (vecs[i].valid) chk($sformatf("vec%0d_data", i), frame_data, vecs[i].data);
        end

        // Backpressure: third frame dropped, first two drained in order.
        do_reset();
        send_frame(8'h01, 1'b0, 1'b0);
        send_frame(8'h03, 1'b0, 1'b0);
        send_frame(8'h07, 1'b0, 1'b0);
        chk("bp_ovf", 8'(overflow), 8'd1);
        chk("bp_cnt", frame_count, 8'd2);
        chk("bp_valid", 8'(frame_valid), 8'd1);
        chk("bp_head", frame_data, 8'h01);
        step(1'b0, 1'b0, 3'd0, 1'b1);
        chk("bp_second", frame_data, 8'h03);
        chk("bp_valid2", 8'(frame_valid), 8'd1);
        step(1'b0, 1'b0, 3'd0, 1'b1);
        chk("bp_drained", 8'(frame_valid), 8'd0);
        chk("bp_ovf_sticky", 8'(overflow), 8'd1);

        // Gaps between valid bits, then a restart on a repeated slot 0.
        do_reset();
        b = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, b[k], 3'(k), 1'b1);
            if (k < 7) step(1'b0, ~b[k], 3'(7 - k), 1'b1);
        end
        chk("gap_valid", 8'(frame_valid), 8'd1);
        chk("gap_data", frame_data, 8'hA5);
        chk("gap_cnt", frame_count, 8'd1);
        step(1'b1, 1'b1, 3'd0, 1'b1);
        step(1'b1, 1'b1, 3'd1, 1'b1);
        b = 8'h3C;
        step(1'b1, b[0], 3'd0, 1'b1);
        chk("restart_err", 8'(slot_err), 8'd1);
        for (int k = 1; k < 8; k++) begin
            step(1'b1, b[k], 3'(k), 1'b1);
            if (k == 1) chk("restart_err_clear", 8'(slot_err), 8'd0);
        end
        chk("restart_valid", 8'(frame_valid), 8'd1);
        chk("restart_data", frame_data, 8'h3C);
        chk("restart_cnt", frame_count, 8'd2);

        // Reset mid-frame: the resumed tail must not form a frame or an error.
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 3'(k), 1'b0);
        do_reset();
        for (int k = 4; k < 8; k++) begin
            step(1'b1, 1'b1, 3'(k), 1'b1);
            chk($sformatf("rmid_err%0d", k), 8'(slot_err), 8'd0);
            chk($sformatf("rmid_valid%0d", k), 8'(frame_valid), 8'd0);
        end
        chk("rmid_cnt", frame_count, 8'd0);

        // Full FIFO with simultaneous pop and push.
        do_reset();
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        send_frame(8'h33, 1'b0, 1'b1);
        chk("pp_ovf", 8'(overflow), 8'd0);
        chk("pp_cnt", frame_count, 8'd3);
        chk("pp_head", frame_data, 8'h22);
        step(1'b0, 1'b0, 3'd0, 1'b1);
        chk("pp_next", frame_data, 8'h33);
        chk("pp_valid", 8'(frame_valid), 8'd1);
        step(1'b0, 1'b0, 3'd0, 1'b1);
        chk("pp_empty", 8'(frame_valid), 8'd0);

        // Randomized run against the model.
        do_reset();
        tn = 0;
        for (int i = 0; i < 3000; i++) begin
            rbv = ($urandom % 4) != 0;
            rsl = (($urandom % 16) == 0) ? 3'($urandom % 8) : 3'(tn);
            if (rbv) tn = (tn + 1) % 8;
            step(rbv, 1'($urandom % 2), rsl, (i < 1500) ? (($urandom % 4) != 0) : (($urandom % 3) == 0));
            chk("rnd_valid", 8'(frame_valid), 8'(mq.size() > 0));
            chk("rnd_err", 8'(slot_err), 8'(m_err));
            chk("rnd_ovf", 8'(overflow), 8'(m_ovf));
            chk("rnd_cnt", frame_count, m_cnt);
            if (mq.size() > 0) chk("rnd_data", frame_data, mq[0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
